// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder datapath: FSM state encoding and
// the bit-counter width helper used by the serial word collector.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package serial_adder_pkg;

    // Collector FSM encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Counter width for a word of w bits: $clog2(w), but never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        if (w <= 1) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Purpose: WIDTH-bit right-shift register; new bit enters at the MSB, so after
//          WIDTH shifts the first bit received sits at bit 0.
// Latency: one edge per shift. Backpressure: none, shifts only when shift_i=1.
// Ports: clk/reset (sync, active-high), clr_i sync clear, shift_i shift strobe,
//        bit_i serial input, data_nxt_o = value the register takes if shifted now.
module sipo_shift_core
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_nxt_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Shift-right form written so that WIDTH=1 needs no special slice.
    always_comb begin
        shreg_d            = shreg_q >> 1;
        shreg_d[WIDTH-1]   = bit_i;
    end

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            shreg_q <= '0;
        end else if (shift_i) begin
            shreg_q <= shreg_d;
        end
    end

    // The top captures the completed word from the pre-edge next value so that
    // word_out is valid on the same edge the last bit is taken.
    assign data_nxt_o = shreg_d;

endmodule

// File: rtl/serial_word_collector.sv
// Purpose: serial-in/parallel-out collector, WIDTH bits LSB first -> word_out
//          with a valid/ready handshake.
// Latency: start at edge k, bits sampled on enabled edges, word_valid after
//          the WIDTH-th enabled edge. Backpressure: holds the word while
//          word_ready=0; serial input is ignored until the handshake.
// Ports: clk, reset (sync, active-high), start, enable (bit strobe), sr_in,
//        busy, word_out, word_valid, word_ready. All outputs registered.
module serial_word_collector
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             sr_in,
    output logic             busy,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  word_q, word_d;

    logic              clr;
    logic              shift;
    logic              load_word;
    logic [WIDTH-1:0]  data_nxt;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (clr),
        .shift_i    (shift),
        .bit_i      (sr_in),
        .data_nxt_o (data_nxt)
    );

    // State register (together with the registered outputs).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr       = 1'b0;
        shift     = 1'b0;
        load_word = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (enable) begin
                    shift = 1'b1;
                    if (cnt_q == LAST) begin
                        // Last bit: counter stays at WIDTH-1 rather than wrapping.
                        state_d   = ST_HOLD;
                        load_word = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    if (start) begin
                        // Back-to-back: skip IDLE so no bubble between words.
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        clr     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: computed from the next state and registered above, so no
    // input reaches an output combinationally.
    always_comb begin
        busy_d  = (state_d == ST_SHIFT);
        valid_d = (state_d == ST_HOLD);
        word_d  = load_word ? data_nxt : word_q;
    end

    assign busy       = busy_q;
    assign word_valid = valid_q;
    assign word_out   = word_q;

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, enable, sr_in, word_ready;
    logic       busy3, valid3;
    logic [2:0] word3;
    logic       busy1, valid1;
    logic [0:0] word1;

    int n_cmp = 0;
    int n_bad = 0;

    serial_word_collector #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .sr_in(sr_in),
        .busy(busy3), .word_out(word3), .word_valid(valid3), .word_ready(word_ready)
    );

    serial_word_collector #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .sr_in(sr_in),
        .busy(busy1), .word_out(word1), .word_valid(valid1), .word_ready(word_ready)
    );

    // Reference model: index 0 models WIDTH=3, index 1 models WIDTH=1.
    // Words are built arithmetically: the i-th received bit has weight 2**i.
    int m_w[2] = '{3, 1};
    int m_busy[2], m_valid[2], m_word[2], m_cnt[2], m_acc[2];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_busy[d] = 0; m_valid[d] = 0; m_word[d] = 0; m_cnt[d] = 0; m_acc[d] = 0;
            end else if (m_valid[d] != 0) begin
                if (word_ready) begin
                    m_valid[d] = 0;
                    if (start) begin
                        m_busy[d] = 1; m_cnt[d] = 0; m_acc[d] = 0;
                    end
                end
            end else if (m_busy[d] != 0) begin
                if (enable) begin
                    m_acc[d] = m_acc[d] + (int'(sr_in) << m_cnt[d]);
                    m_cnt[d] = m_cnt[d] + 1;
                    if (m_cnt[d] == m_w[d]) begin
                        m_word[d] = m_acc[d]; m_busy[d] = 0; m_valid[d] = 1;
                    end
                end
            end else if (start) begin
                m_busy[d] = 1; m_cnt[d] = 0; m_acc[d] = 0;
            end
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; enable = 0; sr_in = 0; word_ready = 0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy3, valid3, word3} !== 5'b0) begin
            n_bad++; $display("FAIL reset_w3: busy/valid/word=%b required 00000", {busy3, valid3, word3});
        end
        n_cmp++;
        if ({busy1, valid1, word1} !== 3'b0) begin
            n_bad++; $display("FAIL reset_w1: busy/valid/word=%b required 000", {busy1, valid1, word1});
        end
    endtask

    task automatic test_basic();
        logic [2:0] bits;
        bits = 3'b101;
        start = 1; enable = 1; sr_in = 0;
        tick();
        start = 0;
        n_cmp++;
        if (busy3 !== 1'b1 || valid3 !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy: busy=%b valid=%b required 1 0", busy3, valid3);
        end
        for (int i = 0; i < 3; i++) begin
            sr_in = bits[i];
            tick();
            if (i < 2) begin
                n_cmp++;
                if (valid3 !== 1'b0) begin
                    n_bad++; $display("FAIL basic_early_valid: bit %0d valid=%b required 0", i, valid3);
                end
            end
        end
        n_cmp++;
        if (valid3 !== 1'b1 || word3 !== 3'b101 || busy3 !== 1'b0) begin
            n_bad++; $display("FAIL basic_word: valid=%b word=%b busy=%b required 1 101 0", valid3, word3, busy3);
        end
        enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
        n_cmp++;
        if (valid3 !== 1'b0) begin
            n_bad++; $display("FAIL basic_release: valid=%b required 0", valid3);
        end
    endtask

    task automatic test_stall();
        start = 1; enable = 0;
        tick();
        start = 0; enable = 1; sr_in = 1;
        tick();
        enable = 0;
        for (int i = 0; i < 4; i++) begin
            sr_in = i[0];
            tick();
            n_cmp++;
            if (valid3 !== 1'b0 || busy3 !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold: cycle %0d valid=%b busy=%b required 0 1", i, valid3, busy3);
            end
        end
        enable = 1; sr_in = 1;
        tick();
        n_cmp++;
        if (valid3 !== 1'b0) begin
            n_bad++; $display("FAIL stall_early: valid=%b required 0", valid3);
        end
        tick();
        n_cmp++;
        if (valid3 !== 1'b1 || word3 !== 3'b111) begin
            n_bad++; $display("FAIL stall_word: valid=%b word=%b required 1 111", valid3, word3);
        end
        enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [2:0] bits;
        bits = 3'b110;
        start = 1; enable = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            sr_in = bits[i];
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            sr_in = 1'($urandom); enable = 1'($urandom); start = 1'($urandom);
            tick();
            n_cmp++;
            if (valid3 !== 1'b1 || word3 !== 3'b110) begin
                n_bad++; $display("FAIL bp_hold: cycle %0d valid=%b word=%b required 1 110", i, valid3, word3);
            end
        end
        start = 0; enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
        n_cmp++;
        if (valid3 !== 1'b0 || busy3 !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: valid=%b busy=%b required 0 0", valid3, busy3);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] a, b;
        a = 3'b001; b = 3'b010;
        start = 1; enable = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin sr_in = a[i]; tick(); end
        n_cmp++;
        if (valid3 !== 1'b1 || word3 !== 3'b001) begin
            n_bad++; $display("FAIL b2b_first: valid=%b word=%b required 1 001", valid3, word3);
        end
        word_ready = 1; start = 1;
        tick();
        word_ready = 0; start = 0;
        n_cmp++;
        if (busy3 !== 1'b1 || valid3 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_handoff: busy=%b valid=%b required 1 0", busy3, valid3);
        end
        for (int i = 0; i < 3; i++) begin sr_in = b[i]; tick(); end
        n_cmp++;
        if (valid3 !== 1'b1 || word3 !== 3'b010) begin
            n_bad++; $display("FAIL b2b_second: valid=%b word=%b required 1 010", valid3, word3);
        end
        enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] bits;
        bits = 3'b100;
        start = 1; enable = 1;
        tick();
        start = 0; sr_in = 1;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        n_cmp++;
        if (busy3 !== 1'b0 || valid3 !== 1'b0 || word3 !== 3'b000) begin
            n_bad++; $display("FAIL midreset: busy=%b valid=%b word=%b required 0 0 000", busy3, valid3, word3);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin sr_in = bits[i]; tick(); end
        n_cmp++;
        if (valid3 !== 1'b1 || word3 !== 3'b100) begin
            n_bad++; $display("FAIL midreset_word: valid=%b word=%b required 1 100", valid3, word3);
        end
        enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
    endtask

    task automatic test_width1();
        reset = 1;
        tick();
        reset = 0;
        start = 1; enable = 0; sr_in = 1;
        tick();
        n_cmp++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
            n_bad++; $display("FAIL w1_start: busy=%b valid=%b required 1 0", busy1, valid1);
        end
        // start stays high through the stall and the bit edge
        tick();
        n_cmp++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0) begin
            n_bad++; $display("FAIL w1_stall: busy=%b valid=%b required 1 0", busy1, valid1);
        end
        enable = 1;
        tick();
        n_cmp++;
        if (valid1 !== 1'b1 || word1 !== 1'b1 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL w1_word: valid=%b word=%b busy=%b required 1 1 0", valid1, word1, busy1);
        end
        start = 0; enable = 0; word_ready = 1;
        tick();
        word_ready = 0;
        n_cmp++;
        if (valid1 !== 1'b0) begin
            n_bad++; $display("FAIL w1_release: valid=%b required 0", valid1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 63) == 0);
            start      = ($urandom_range(0, 3) == 0);
            enable     = 1'($urandom);
            sr_in      = 1'($urandom);
            word_ready = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++;
            if (busy3 !== 1'(m_busy[0]) || valid3 !== 1'(m_valid[0]) || word3 !== 3'(m_word[0])) begin
                n_bad++;
                $display("FAIL rand_w3: cycle %0d busy/valid/word=%b/%b/%b required %0d/%0d/%0d",
                         c, busy3, valid3, word3, m_busy[0], m_valid[0], m_word[0]);
            end
            n_cmp++;
            if (busy1 !== 1'(m_busy[1]) || valid1 !== 1'(m_valid[1]) || word1 !== 1'(m_word[1])) begin
                n_bad++;
                $display("FAIL rand_w1: cycle %0d busy/valid/word=%b/%b/%b required %0d/%0d/%0d",
                         c, busy1, valid1, word1, m_busy[1], m_valid[1], m_word[1]);
            end
        end
        reset = 0; start = 0; enable = 0; word_ready = 0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_valid[d] = 0; m_word[d] = 0; m_cnt[d] = 0; m_acc[d] = 0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
